// File: rtl/game_sequencer_if.sv
// game_sequencer_if
// Bundles everything the game controller exchanges with the rest of the VGA
// game except clock and reset.
//   Inputs to the controller : startOfFrame, req_bird/req_borders/
//                              req_fortress/req_pig (per-pixel drawing
//                              requests), shoot_pulse, bird_active,
//                              start_key, pause_key, skip_key.
//   Outputs of the controller: coll_bird/coll_fortress/coll_pig
//                              (combinational), hit_pulse, score,
//                              high_score (packed BCD), level, birds_left,
//                              pigs_left, screen, game_active,
//                              new_level_pulse.
// Modport slave is the controller's view, master is the environment's view.
interface game_sequencer_if #(
  parameter int SCORE_DIGITS = 3
);
  logic                        startOfFrame;
  logic                        req_bird;
  logic                        req_borders;
  logic                        req_fortress;
  logic                        req_pig;
  logic                        shoot_pulse;
  logic                        bird_active;
  logic                        start_key;
  logic                        pause_key;
  logic                        skip_key;
  logic                        coll_bird;
  logic                        coll_fortress;
  logic                        coll_pig;
  logic                        hit_pulse;
  logic [4*SCORE_DIGITS-1:0]   score;
  logic [4*SCORE_DIGITS-1:0]   high_score;
  logic [3:0]                  level;
  logic [7:0]                  birds_left;
  logic [3:0]                  pigs_left;
  logic [2:0]                  screen;
  logic                        game_active;
  logic                        new_level_pulse;

  modport slave (
    input  startOfFrame, req_bird, req_borders, req_fortress, req_pig,
           shoot_pulse, bird_active, start_key, pause_key, skip_key,
    output coll_bird, coll_fortress, coll_pig, hit_pulse, score, high_score,
           level, birds_left, pigs_left, screen, game_active, new_level_pulse
  );

  modport master (
    output startOfFrame, req_bird, req_borders, req_fortress, req_pig,
           shoot_pulse, bird_active, start_key, pause_key, skip_key,
    input  coll_bird, coll_fortress, coll_pig, hit_pulse, score, high_score,
           level, birds_left, pigs_left, screen, game_active, new_level_pulse
  );
endinterface

// File: rtl/game_sequencer.sv
// game_sequencer
// Game-flow controller for the bird/pig game: collision detection from
// drawing requests, per-level bird/pig bookkeeping, a digit-serial BCD score
// adder (one digit per cycle, saturating at all 9s), end-of-level bonus per
// unused bird, pause, level skip and a persistent high score.
// Ports:
//   clk    - system clock
//   resetN - asynchronous active-low reset, clears everything incl. high score
//   bus    - game_sequencer_if.slave carrying all game inputs and outputs
module game_sequencer #(
  parameter int                        NUM_LEVELS   = 5,
  parameter int                        NUM_PIGS     = 3,
  parameter int                        NUM_BIRDS    = 10,
  parameter int                        SCORE_DIGITS = 3,
  parameter logic [4*SCORE_DIGITS-1:0] HIT_BCD      = 12'h030,
  parameter logic [4*SCORE_DIGITS-1:0] BONUS_BCD    = 12'h001
) (
  input logic             clk,
  input logic             resetN,
  game_sequencer_if.slave bus
);

  localparam int              W          = 4 * SCORE_DIGITS;
  localparam logic [2:0]      LAST_DIGIT = 3'(SCORE_DIGITS - 1);
  localparam logic [3:0]      LAST_LEVEL = 4'(NUM_LEVELS - 1);
  localparam logic [7:0]      BIRDS_INIT = 8'(NUM_BIRDS);
  localparam logic [3:0]      PIGS_INIT  = 4'(NUM_PIGS);
  localparam logic [W-1:0]    ALL_NINES  = {SCORE_DIGITS{4'd9}};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLAY      = 3'd1,
    S_LOSE      = 3'd2,
    S_WIN       = 3'd3,
    S_SCORE_ADD = 3'd4,
    S_LEVEL_END = 3'd5,
    S_PAUSE     = 3'd6
  } state_e;

  // One BCD digit add: returns {carry_out, digit}.
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] a,
                                               input logic [3:0] b,
                                               input logic       cin);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    if (s > 5'd9) begin
      bcd_digit_add = {1'b1, 4'(s - 5'd10)};
    end else begin
      bcd_digit_add = {1'b0, s[3:0]};
    end
  endfunction

  state_e         state_q, state_d;
  logic [W-1:0]   score_q, score_d;
  logic [W-1:0]   high_q, high_d;
  logic [W-1:0]   work_q, work_d;
  logic [W-1:0]   addend_q, addend_d;
  logic [2:0]     digit_q, digit_d;
  logic           carry_q, carry_d;
  logic [3:0]     level_q, level_d;
  logic [7:0]     birds_q, birds_d;
  logic [3:0]     pigs_q, pigs_d;
  logic           pig_flag_q, pig_flag_d;
  logic           hit_flag_q, hit_flag_d;
  logic           hit_pulse_q, hit_pulse_d;
  logic           nlp_q, nlp_d;
  logic           active_q, active_d;
  logic           pause_dly_q, skip_dly_q;

  logic           coll_bird_s;
  logic           pig_hit_s;
  logic           pause_rise_s;
  logic           skip_rise_s;
  logic [7:0]     birds_shot_s;
  logic [3:0]     score_dig_s;
  logic [3:0]     addend_dig_s;
  logic [4:0]     digit_res_s;
  logic [W-1:0]   work_merge_s;
  logic [W-1:0]   sum_final_s;

  assign coll_bird_s       = bus.req_bird & (bus.req_borders | bus.req_fortress | bus.req_pig);
  assign bus.coll_bird     = coll_bird_s;
  assign bus.coll_fortress = bus.req_bird & bus.req_fortress;
  assign bus.coll_pig      = bus.req_bird & bus.req_pig;

  assign pause_rise_s = bus.pause_key & ~pause_dly_q;
  assign skip_rise_s  = bus.skip_key & ~skip_dly_q;
  // Only the first pig collision of a frame counts, and only while playing.
  assign pig_hit_s    = (state_q == S_PLAY) & bus.req_bird & bus.req_pig & ~pig_flag_q;
  // birds_left saturates at zero on a shot.
  assign birds_shot_s = (bus.shoot_pulse && (birds_q != 8'd0)) ? (birds_q - 8'd1) : birds_q;

  // Serial BCD datapath: selects the current digit and merges the result.
  always_comb begin
    score_dig_s  = 4'd0;
    addend_dig_s = 4'd0;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      score_dig_s  = (digit_q == 3'(i)) ? score_q[4*i +: 4]  : score_dig_s;
      addend_dig_s = (digit_q == 3'(i)) ? addend_q[4*i +: 4] : addend_dig_s;
    end
    digit_res_s  = bcd_digit_add(score_dig_s, addend_dig_s, carry_q);
    work_merge_s = work_q;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      work_merge_s[4*i +: 4] = (digit_q == 3'(i)) ? digit_res_s[3:0] : work_q[4*i +: 4];
    end
    // A carry out of the top digit clamps the score instead of wrapping.
    sum_final_s = digit_res_s[4] ? ALL_NINES : work_merge_s;
  end

  // Next-state and datapath control for the game flow.
  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    high_d   = high_q;
    work_d   = work_q;
    addend_d = addend_q;
    digit_d  = digit_q;
    carry_d  = carry_q;
    level_d  = level_q;
    birds_d  = birds_q;
    pigs_d   = pigs_q;
    nlp_d    = 1'b0;

    case (state_q)
      S_IDLE, S_LOSE, S_WIN: begin
        if (bus.start_key) begin
          score_d = '0;
          level_d = 4'd0;
          birds_d = BIRDS_INIT;
          pigs_d  = PIGS_INIT;
          state_d = S_PLAY;
        end else begin
          state_d = state_q;
        end
      end
      S_PLAY: begin
        if (pause_rise_s) begin
          state_d = S_PAUSE;
        end else if (pig_hit_s) begin
          pigs_d   = pigs_q - 4'd1;
          birds_d  = birds_shot_s;
          addend_d = HIT_BCD;
          digit_d  = 3'd0;
          carry_d  = 1'b0;
          state_d  = S_SCORE_ADD;
        end else if (skip_rise_s) begin
          if (level_q == LAST_LEVEL) begin
            state_d = S_WIN;
          end else begin
            level_d = level_q + 4'd1;
            nlp_d   = 1'b1;
            birds_d = BIRDS_INIT;
            pigs_d  = PIGS_INIT;
          end
        end else begin
          birds_d = birds_shot_s;
          if ((birds_q == 8'd0) && !bus.bird_active && (pigs_q != 4'd0)) begin
            state_d = S_LOSE;
          end else begin
            state_d = S_PLAY;
          end
        end
      end
      S_SCORE_ADD: begin
        work_d  = work_merge_s;
        carry_d = digit_res_s[4];
        if (digit_q == LAST_DIGIT) begin
          score_d = sum_final_s;
          state_d = (pigs_q == 4'd0) ? S_LEVEL_END : S_PLAY;
        end else begin
          digit_d = digit_q + 3'd1;
        end
      end
      S_LEVEL_END: begin
        if (bus.bird_active) begin
          state_d = S_LEVEL_END;
        end else if (birds_q != 8'd0) begin
          // Each unused bird costs one cycle here plus one add pass.
          birds_d  = birds_q - 8'd1;
          addend_d = BONUS_BCD;
          digit_d  = 3'd0;
          carry_d  = 1'b0;
          state_d  = S_SCORE_ADD;
        end else if (level_q == LAST_LEVEL) begin
          state_d = S_WIN;
        end else begin
          level_d = level_q + 4'd1;
          nlp_d   = 1'b1;
          birds_d = BIRDS_INIT;
          pigs_d  = PIGS_INIT;
          state_d = S_PLAY;
        end
      end
      S_PAUSE: begin
        if (pause_rise_s) begin
          state_d = S_PLAY;
        end else begin
          state_d = S_PAUSE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Score is stable on entry to an end screen, so compare the current value.
    if ((state_d == S_LOSE || state_d == S_WIN) && (state_d != state_q) && (score_q > high_q)) begin
      high_d = score_q;
    end else begin
      high_d = high_d;
    end

    active_d = (state_d == S_PLAY) || (state_d == S_SCORE_ADD) ||
               (state_d == S_LEVEL_END) || (state_d == S_PAUSE);
  end

  // Per-frame flags: set on the counted event, cleared by startOfFrame.
  always_comb begin
    hit_pulse_d = coll_bird_s & ~hit_flag_q;
    if (hit_pulse_d) begin
      hit_flag_d = 1'b1;
    end else begin
      hit_flag_d = bus.startOfFrame ? 1'b0 : hit_flag_q;
    end
    if (pig_hit_s) begin
      pig_flag_d = 1'b1;
    end else begin
      pig_flag_d = bus.startOfFrame ? 1'b0 : pig_flag_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= S_IDLE;
      score_q     <= '0;
      high_q      <= '0;
      work_q      <= '0;
      addend_q    <= '0;
      digit_q     <= 3'd0;
      carry_q     <= 1'b0;
      level_q     <= 4'd0;
      birds_q     <= 8'd0;
      pigs_q      <= 4'd0;
      pig_flag_q  <= 1'b0;
      hit_flag_q  <= 1'b0;
      hit_pulse_q <= 1'b0;
      nlp_q       <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      high_q      <= high_d;
      work_q      <= work_d;
      addend_q    <= addend_d;
      digit_q     <= digit_d;
      carry_q     <= carry_d;
      level_q     <= level_d;
      birds_q     <= birds_d;
      pigs_q      <= pigs_d;
      pig_flag_q  <= pig_flag_d;
      hit_flag_q  <= hit_flag_d;
      hit_pulse_q <= hit_pulse_d;
      nlp_q       <= nlp_d;
      active_q    <= active_d;
    end
  end

  // Delayed key copies for rising-edge detection.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pause_dly_q <= 1'b0;
      skip_dly_q  <= 1'b0;
    end else begin
      pause_dly_q <= bus.pause_key;
      skip_dly_q  <= bus.skip_key;
    end
  end

  assign bus.hit_pulse       = hit_pulse_q;
  assign bus.score           = score_q;
  assign bus.high_score      = high_q;
  assign bus.level           = level_q;
  assign bus.birds_left      = birds_q;
  assign bus.pigs_left       = pigs_q;
  assign bus.screen          = state_q;
  assign bus.game_active     = active_q;
  assign bus.new_level_pulse = nlp_q;

endmodule
